fp32_mul_seq: RTL and testbench
===============================

Name: fp32_mul_seq

Overview:
- Sequential IEEE-754 single-precision multiplier built around the team's 32x32 signed sequential Booth multiplier (boothAlgo).
- Unpacks both operands and issues the 24-bit significands to the Booth core. Waits for the product, then normalizes, rounds to nearest-even and repacks.
- Has valid/ready handshakes on both sides. Sits between the operand register file / FPU decode and the FPU result writeback.

Parameters:
MUL_LAT, 33, cycles from the Booth enable edge until its 64-bit product is stable (load edge plus 32 iteration edges).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in_a  in  32  operand A, fp32
in_b  in  32  operand B, fp32
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_res  out  32  fp32 product
out_flags  out  4  {inv, ovf, udf, inx}
mul_reset  out  1  to Booth reset; equals ~reset (combinational)
mul_enable  out  1  to Booth enable
mul_a  out  32  to Booth A
mul_b  out  32  to Booth B
mul_res  in  64  from Booth Res

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, in_ready=1, out_valid=0, out_res=0, out_flags=0.
  - mul_enable=0, mul_a=0, mul_b=0, wait counter=0.
  - Reset mid-operation aborts the operation. The Booth core is reset via mul_reset. No partial result is ever emitted.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready, register operands and classify them.
    - Special case present: go to DONE.
    - Otherwise: go to ISSUE.
  - ISSUE (1 cycle): mul_a={8'b0,1,frac_a}, mul_b={8'b0,1,frac_b}, mul_enable=1. Load counter=MUL_LAT-1. Go to WAIT.
  - WAIT: mul_enable=0; mul_a/mul_b held. Counter decrements; at 0, register mul_res[47:0] into P and go to ROUND.
  - ROUND (1 cycle): normalize, round, pack, set flags. Go to DONE.
  - DONE: out_valid=1, with out_res/out_flags stable. On out_ready, go to IDLE.
    - out_valid drops the cycle after the handshake.
    - in_ready returns in the same cycle.
- Latency, accept edge to out_valid high:
  - Normal path: MUL_LAT+3 cycles.
  - Special-case path: 1 cycle.
- in_ready=0 in every state except IDLE. There is no pipelining: one operation in flight.
- Sign: s = a[31]^b[31] for every result, including zero, inf and overflow. NaN has no sign rule.
- Classification:
  - exp=0 means zero; subnormal inputs are flushed to zero (DAZ).
  - exp=255 with frac=0 is inf; exp=255 with frac!=0 is NaN.
- Special cases, in priority order:
  - Any NaN, or inf*0 → 0x7FC00000; inv=1 only for inf*0 and sNaN (frac[22]=0).
  - Any inf → {s,0xFF,0}.
  - Any zero → {s,31'b0}.
- Exponent: E = ea+eb-127, computed 10-bit signed.
- Normalization:
  - P[47]=1: mant=P[46:24], g=P[23], st=|P[22:0], E=E+1.
  - Otherwise: mant=P[45:23], g=P[22], st=|P[21:0].
- Rounding (RNE): round up iff g&(st|mant[0]). A mantissa carry-out sets mant=0 and E=E+1.
- inx = g|st.
- Result selection:
  - E>=255: {s,0xFF,0}, ovf=1, inx=1.
  - E<=0: {s,31'b0} (FTZ), udf=1, inx=1.
  - Otherwise: {s,E[7:0],mant}.
- Simultaneous out_ready and in_valid in DONE: only the output handshake completes. The new operand is accepted next cycle in IDLE.

Decomposition:
- Shared package fp32_pkg holds:
  - Constants: FP32_EXP_BIAS=127, FP32_QNAN=32'h7FC00000.
  - Field widths: EXP_W=8, FRAC_W=23.
  - State encoding: IDLE/ISSUE/WAIT/ROUND/DONE.
  - Flag bit indices.
- One natural sub-module: fp32_norm_round. It is purely combinational: P[47:0], E, s → packed result and flags. It is instantiated in ROUND.
- The Booth core is instantiated by the enclosing FPU top, not inside this block.

Test Plan:
- 0x40000000 * 0x40400000 (2.0*3.0), out_ready=1 → out_res=0x40C00000, flags=0, out_valid exactly MUL_LAT+3 cycles after accept.
- 0x3FC00000 * 0x3FC00000 (1.5*1.5) → 0x40100000, flags=0. 0x3F800001 * 0x3F800001 → 0x3F800002, inx=1.
- 0x7F800000 * 0x00000000 → 0x7FC00000, inv=1, 1-cycle latency, mul_enable never asserted. 0xFF800000 * 0x40000000 → 0xFF800000.
- 0x7F000000 * 0x7F000000 → 0x7F800000, ovf=1, inx=1. 0x00800000 * 0x00800000 → 0x00000000, udf=1, inx=1. 0x80800000 * 0x00800000 → 0x80000000.
- Hold out_ready=0 for 10 cycles after out_valid → out_res stable, in_ready=0, in_valid ignored; release → next operation accepted the cycle after the handshake.
- Deassert reset during WAIT → same cycle: out_valid=0, in_ready=1, mul_reset=1. After release, a fresh 2.0*3.0 yields 0x40C00000.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared fp32 constants, field widths, FSM encoding, flag indices and
// operand classification helpers for the sequential fp32 multiplier.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [9:0]  FP32_EXP_BIAS = 10'd127;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

  // Bit positions inside the {inv, ovf, udf, inx} flag vector
  localparam int FLAG_INV = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UDF = 1;
  localparam int FLAG_INX = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Exponent 0 covers true zeros and subnormals (flushed to zero on input)
  function automatic logic fp_is_zero(input logic [31:0] x);
    return (x[30:23] == 8'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Signalling NaN has the quiet bit clear
  function automatic logic fp_is_snan(input logic [31:0] x);
    return fp_is_nan(x) && !x[22];
  endfunction

endpackage

// File: rtl/fp32_mul_seq_if.sv
// Operand / result handshake bundle of the sequential fp32 multiplier.
interface fp32_mul_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_flags;

  // Requester side: operand source and result consumer
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );

  // Multiplier side
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );

endinterface

// File: rtl/fp32_norm_round.sv
// Normalizes the 48-bit significand product, rounds to nearest-even and
// packs the fp32 result with overflow / underflow (flush-to-zero) handling.
module fp32_norm_round
  import fp32_pkg::*;
(
  input  logic [47:0]       p,
  input  logic signed [9:0] e,
  input  logic              s,
  output logic [31:0]       res,
  output logic [3:0]        flags
);

  logic [22:0]       mant_s;
  logic              guard_s;
  logic              sticky_s;
  logic              round_up_s;
  logic [23:0]       mant_rnd_s;
  logic signed [9:0] e_norm_s;
  logic signed [9:0] e_fin_s;

  // Normalize, round to nearest-even, then select normal / overflow / FTZ result
  always_comb begin
    mant_s     = 23'd0;
    guard_s    = 1'b0;
    sticky_s   = 1'b0;
    e_norm_s   = e;
    round_up_s = 1'b0;
    mant_rnd_s = 24'd0;
    e_fin_s    = e;
    res        = 32'd0;
    flags      = 4'd0;

    if (p[47]) begin
      mant_s   = p[46:24];
      guard_s  = p[23];
      sticky_s = |p[22:0];
      e_norm_s = e + 10'sd1;
    end else begin
      mant_s   = p[45:23];
      guard_s  = p[22];
      sticky_s = |p[21:0];
      e_norm_s = e;
    end

    round_up_s = guard_s & (sticky_s | mant_s[0]);
    mant_rnd_s = {1'b0, mant_s} + {23'd0, round_up_s};

    // A carry out of the mantissa leaves the low 23 bits at zero
    if (mant_rnd_s[23]) begin
      e_fin_s = e_norm_s + 10'sd1;
    end else begin
      e_fin_s = e_norm_s;
    end

    flags[FLAG_INX] = guard_s | sticky_s;

    if (e_fin_s >= 10'sd255) begin
      res             = {s, 8'hFF, 23'd0};
      flags[FLAG_OVF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
    end else if (e_fin_s <= 10'sd0) begin
      res             = {s, 31'd0};
      flags[FLAG_UDF] = 1'b1;
      flags[FLAG_INX] = 1'b1;
    end else begin
      res = {s, e_fin_s[7:0], mant_rnd_s[22:0]};
    end
  end

endmodule

// File: rtl/fp32_mul_seq.sv
// Sequential fp32 multiplier: classifies operands, hands the 24-bit
// significands to an external Booth core, then normalizes, rounds and
// returns the packed product over a valid/ready handshake.
module fp32_mul_seq
  import fp32_pkg::*;
#(
  parameter int MUL_LAT = 33
)
(
  input  logic               clk,
  input  logic               reset,
  fp32_mul_seq_if.slave      bus,
  output logic               mul_reset,
  output logic               mul_enable,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [63:0]        mul_res
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               s_r;
  logic signed [9:0]  e_r;
  logic [47:0]        p_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        out_res_r;
  logic [3:0]         out_flags_r;
  logic               mul_enable_r;
  logic [31:0]        mul_a_r;
  logic [31:0]        mul_b_r;

  logic               sign_s;
  logic [9:0]         e_sum_s;
  logic               spec_hit_s;
  logic [31:0]        spec_res_s;
  logic [3:0]         spec_flags_s;
  logic               inf_zero_s;
  logic [31:0]        nr_res_s;
  logic [3:0]         nr_flags_s;

  // The Booth core is held in reset exactly while this block is
  assign mul_reset  = ~reset;

  assign mul_enable    = mul_enable_r;
  assign mul_a         = mul_a_r;
  assign mul_b         = mul_b_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_res   = out_res_r;
  assign bus.out_flags = out_flags_r;

  // Classify incoming operands and resolve NaN / inf / zero results up front
  always_comb begin
    sign_s       = bus.in_a[31] ^ bus.in_b[31];
    e_sum_s      = {2'b00, bus.in_a[30:23]} + {2'b00, bus.in_b[30:23]} - FP32_EXP_BIAS;
    inf_zero_s   = (fp_is_inf(bus.in_a) && fp_is_zero(bus.in_b)) ||
                   (fp_is_inf(bus.in_b) && fp_is_zero(bus.in_a));
    spec_hit_s   = 1'b0;
    spec_res_s   = 32'd0;
    spec_flags_s = 4'd0;
    if (fp_is_nan(bus.in_a) || fp_is_nan(bus.in_b) || inf_zero_s) begin
      spec_hit_s             = 1'b1;
      spec_res_s             = FP32_QNAN;
      spec_flags_s[FLAG_INV] = inf_zero_s || fp_is_snan(bus.in_a) || fp_is_snan(bus.in_b);
    end else if (fp_is_inf(bus.in_a) || fp_is_inf(bus.in_b)) begin
      spec_hit_s = 1'b1;
      spec_res_s = {sign_s, 8'hFF, 23'd0};
    end else if (fp_is_zero(bus.in_a) || fp_is_zero(bus.in_b)) begin
      spec_hit_s = 1'b1;
      spec_res_s = {sign_s, 31'd0};
    end else begin
      spec_hit_s = 1'b0;
    end
  end

  fp32_norm_round u_norm_round (
    .p     (p_r),
    .e     (e_r),
    .s     (s_r),
    .res   (nr_res_s),
    .flags (nr_flags_s)
  );

  // Operation sequencer: accept, issue to Booth, wait, round, hold result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      s_r          <= 1'b0;
      e_r          <= 10'sd0;
      p_r          <= 48'd0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_res_r    <= 32'd0;
      out_flags_r  <= 4'd0;
      mul_enable_r <= 1'b0;
      mul_a_r      <= 32'd0;
      mul_b_r      <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            s_r        <= sign_s;
            e_r        <= $signed(e_sum_s);
            if (spec_hit_s) begin
              out_res_r   <= spec_res_s;
              out_flags_r <= spec_flags_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              mul_a_r      <= {8'd0, 1'b1, bus.in_a[22:0]};
              mul_b_r      <= {8'd0, 1'b1, bus.in_b[22:0]};
              mul_enable_r <= 1'b1;
              state_r      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          mul_enable_r <= 1'b0;
          cnt_r        <= CNT_W'(MUL_LAT - 1);
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            p_r     <= mul_res[47:0];
            state_r <= ST_ROUND;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_ROUND: begin
          out_res_r   <= nr_res_s;
          out_flags_r <= nr_flags_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          in_ready_r   <= 1'b1;
          out_valid_r  <= 1'b0;
          mul_enable_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq with a behavioural Booth core model
// and a queue scoreboard of expected {result, flags}.
`timescale 1ns/1ps
module tb_fp32_mul_seq;

  localparam int MUL_LAT = 33;
  localparam int LAT_NORM = MUL_LAT + 3;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mul_reset;
  logic        mul_enable;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_res;

  int total = 0;
  int bad = 0;
  int en_count = 0;
  logic [35:0] sb_q[$];

  fp32_mul_seq_if bus ();

  fp32_mul_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mul_reset  (mul_reset),
    .mul_enable (mul_enable),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_res    (mul_res)
  );

  always #5 clk = ~clk;

  // Booth core model: garbage on mul_res until 32 iteration edges after the load edge
  int          booth_cnt;
  logic [63:0] booth_prod;
  always @(posedge clk or posedge mul_reset) begin
    if (mul_reset) begin
      booth_cnt  <= 0;
      booth_prod <= 64'd0;
      mul_res    <= 64'd0;
    end else if (mul_enable) begin
      booth_prod <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
      booth_cnt  <= MUL_LAT - 1;
      mul_res    <= 64'h5A5A_5A5A_5A5A_5A5A;
    end else if (booth_cnt > 0) begin
      booth_cnt <= booth_cnt - 1;
      mul_res   <= (booth_cnt == 1) ? booth_prod : ~booth_prod;
    end
  end

  // Count cycles in which the Booth core is started
  always @(posedge clk) begin
    if (mul_enable === 1'b1) en_count <= en_count + 1;
  end

  vec_t norm_v [8] = '{
    {32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'h0},
    {32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'h0},
    {32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'h1},
    {32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'h1},
    {32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 4'h1},
    {32'h3F80_0001, 32'h3FFF_FFFE, 32'h4000_0000, 4'h1},
    {32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'h1},
    {32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 4'h0}
  };

  vec_t spec_v [8] = '{
    {32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'h8},
    {32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'h0},
    {32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'h0},
    {32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'h8},
    {32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'h0},
    {32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'h0},
    {32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 4'h0},
    {32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 4'h0}
  };

  vec_t range_v [3] = '{
    {32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'h5},
    {32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'h3},
    {32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 4'h3}
  };

  // Present one operand pair and wait (bounded) for it to be accepted
  task automatic send(input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat counts negedges after the accept edge, 0 = timeout
  task automatic recv(output logic [31:0] res, output logic [3:0] flags, output int lat);
    lat = 0;
    res = 32'd0;
    flags = 4'd0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = i;
        res = bus.out_res;
        flags = bus.out_flags;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_res !== 32'd0) begin bad++; $display("FAIL reset_out_res got=%h want=0", bus.out_res); end
    total++; if (bus.out_flags !== 4'd0) begin bad++; $display("FAIL reset_out_flags got=%h want=0", bus.out_flags); end
    total++; if (mul_enable !== 1'b0) begin bad++; $display("FAIL reset_mul_enable got=%b want=0", mul_enable); end
    total++; if ({mul_a, mul_b} !== 64'd0) begin bad++; $display("FAIL reset_mul_ab got=%h/%h want=0", mul_a, mul_b); end
    total++; if (mul_reset !== 1'b1) begin bad++; $display("FAIL reset_mul_reset got=%b want=1", mul_reset); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (mul_reset !== 1'b0) begin bad++; $display("FAIL release_mul_reset got=%b want=0", mul_reset); end
  endtask

  // Run a table of operations with out_ready held high and check result, flags, latency
  task automatic run_table(input vec_t v, input int exp_lat, input int exp_en, input string tag);
    logic [31:0] r;
    logic [3:0]  f;
    logic [35:0] e;
    int lat;
    int en0;
    bit ok;
    bus.out_ready = 1'b1;
    en0 = en_count;
    sb_q.push_back({v.res, v.flags});
    send(v.a, v.b, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_accept a=%h b=%h got=timeout want=accept", tag, v.a, v.b); end
    recv(r, f, lat);
    e = sb_q.pop_front();
    total++; if (r !== e[35:4]) begin bad++; $display("FAIL %s_res a=%h b=%h got=%h want=%h", tag, v.a, v.b, r, e[35:4]); end
    total++; if (f !== e[3:0]) begin bad++; $display("FAIL %s_flags a=%h b=%h got=%h want=%h", tag, v.a, v.b, f, e[3:0]); end
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL %s_latency a=%h b=%h got=%0d want=%0d", tag, v.a, v.b, lat, exp_lat); end
    @(posedge clk);
    #1;
    total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL %s_handshake got=v%b/r%b want=v0/r1", tag, bus.out_valid, bus.in_ready); end
    total++; if (en_count - en0 !== exp_en) begin bad++; $display("FAIL %s_booth_starts got=%0d want=%0d", tag, en_count - en0, exp_en); end
  endtask

  task automatic test_normal();
    for (int i = 0; i < 8; i++) run_table(norm_v[i], LAT_NORM, 1, "normal");
  endtask

  task automatic test_special();
    for (int i = 0; i < 8; i++) run_table(spec_v[i], 1, 0, "special");
  endtask

  task automatic test_range();
    for (int i = 0; i < 3; i++) run_table(range_v[i], LAT_NORM, 1, "range");
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [3:0]  f;
    logic [35:0] e;
    int lat;
    bit ok;
    bus.out_ready = 1'b0;
    sb_q.push_back({32'h40C0_0000, 4'h0});
    send(32'h4000_0000, 32'h4040_0000, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_accept got=timeout want=accept"); end
    recv(r, f, lat);
    e = sb_q.pop_front();
    total++; if ({r, f} !== e) begin bad++; $display("FAIL bp_first got=%h/%h want=%h/%h", r, f, e[35:4], e[3:0]); end
    sb_q.push_back({32'h4010_0000, 4'h0});
    bus.in_a = 32'h3FC0_0000;
    bus.in_b = 32'h3FC0_0000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus.out_valid, bus.in_ready, bus.out_res} !== {2'b10, e[35:4]}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=v%b/r%b/%h want=v1/r0/%h", i, bus.out_valid, bus.in_ready, bus.out_res, e[35:4]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=v%b/r%b want=v0/r1", bus.out_valid, bus.in_ready); end
    @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=r%b want=r0", bus.in_ready); end
    bus.in_valid = 1'b0;
    recv(r, f, lat);
    e = sb_q.pop_front();
    total++; if ({r, f} !== e) begin bad++; $display("FAIL bp_second got=%h/%h want=%h/%h", r, f, e[35:4], e[3:0]); end
    total++; if (lat !== LAT_NORM) begin bad++; $display("FAIL bp_second_latency got=%0d want=%0d", lat, LAT_NORM); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [3:0]  f;
    logic [35:0] e;
    int lat;
    bit ok;
    bit seen;
    bus.out_ready = 1'b1;
    sb_q.push_back({32'h40C0_0000, 4'h0});
    send(32'h4000_0000, 32'h4040_0000, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_accept got=timeout want=accept"); end
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if ({bus.out_valid, bus.in_ready, mul_reset, mul_enable} !== 4'b0110) begin
      bad++; $display("FAIL mid_reset got=v%b/r%b/mr%b/me%b want=v0/r1/mr1/me0", bus.out_valid, bus.in_ready, mul_reset, mul_enable);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL mid_no_partial got=out_valid want=quiet"); end
    sb_q.push_back({32'h40C0_0000, 4'h0});
    send(32'h4000_0000, 32'h4040_0000, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_fresh_accept got=timeout want=accept"); end
    recv(r, f, lat);
    e = sb_q.pop_front();
    total++; if ({r, f} !== e) begin bad++; $display("FAIL mid_fresh got=%h/%h want=%h/%h", r, f, e[35:4], e[3:0]); end
    total++; if (lat !== LAT_NORM) begin bad++; $display("FAIL mid_fresh_latency got=%0d want=%0d", lat, LAT_NORM); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = 32'd0;
    bus.in_b = 32'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
